adc_decimator: RTL and testbench

ADC_DECIMATOR -- requirements
Module: adc_decimator

---
 rtl/adc_pkg.sv | 31 +++
 rtl/adc_minmax_track.sv | 47 ++++
 rtl/adc_decimator.sv | 129 ++++++++++++
 tb/tb_adc_decimator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC sample type, widths and signed min/max helpers
package adc_pkg;

    localparam int DATA_W_DEFAULT = 16;

    // Helpers compare at a fixed wide width so any DATA_W up to 32 can use them
    // after sign-extending its operands with a size cast.
    localparam int CMP_W = 32;

    typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;

    typedef enum logic {
        FILL = 1'b0,
        DUMP = 1'b1
    } dec_state_t;

    function automatic logic signed [CMP_W-1:0] smin(
        input logic signed [CMP_W-1:0] a,
        input logic signed [CMP_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [CMP_W-1:0] smax(
        input logic signed [CMP_W-1:0] a,
        input logic signed [CMP_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_minmax_track.sv
// rtl/adc_minmax_track.sv - running signed min/max of a frame with seed and restart
module adc_minmax_track
    import adc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample,
    input  logic                     sample_valid,
    input  logic                     seed,
    input  logic                     restart,
    output logic signed [DATA_W-1:0] frame_min,
    output logic signed [DATA_W-1:0] frame_max
);

    logic signed [DATA_W-1:0] min_q;
    logic signed [DATA_W-1:0] max_q;

    // Extremes including the current sample; a seeding sample starts the frame fresh
    always_comb begin
        frame_min = min_q;
        frame_max = max_q;
        if (seed) begin
            frame_min = sample;
            frame_max = sample;
        end else begin
            frame_min = DATA_W'(smin(CMP_W'(min_q), CMP_W'(sample)));
            frame_max = DATA_W'(smax(CMP_W'(max_q), CMP_W'(sample)));
        end
    end

    // Trackers clear on restart (frame just emitted) and otherwise follow accepted samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_q <= '0;
            max_q <= '0;
        end else if (restart) begin
            min_q <= '0;
            max_q <= '0;
        end else if (sample_valid) begin
            min_q <= frame_min;
            max_q <= frame_max;
        end
    end

endmodule

// File: rtl/adc_decimator.sv
// rtl/adc_decimator.sv - block-average decimator by 2**LOG2_DECIM with frame min/max and overrun flag
module adc_decimator
    import adc_pkg::*;
#(
    parameter int LOG2_DECIM = 3,
    parameter int DATA_W     = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic signed [DATA_W-1:0] out_min,
    output logic signed [DATA_W-1:0] out_max,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun,
    input  logic                     clear_overrun
);

    // N samples of DATA_W bits sum into DATA_W+LOG2_DECIM bits without overflow
    localparam int ACC_W = DATA_W + LOG2_DECIM;

    dec_state_t state;
    dec_state_t state_next;

    logic [LOG2_DECIM-1:0]   count;
    logic                    first;
    logic                    last;
    logic                    load_result;
    logic                    handshake;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] avg_full;
    logic signed [DATA_W-1:0] frame_min;
    logic signed [DATA_W-1:0] frame_max;

    assign first     = (count == '0);
    assign last      = in_valid && (count == {LOG2_DECIM{1'b1}});
    assign handshake = out_valid && out_ready;
    assign in_ext    = ACC_W'(in_data);
    assign sum       = first ? in_ext : (acc + in_ext);
    assign avg_full  = sum >>> LOG2_DECIM;

    adc_minmax_track #(
        .DATA_W(DATA_W)
    ) u_minmax (
        .clk         (clk),
        .reset       (reset),
        .sample      (in_data),
        .sample_valid(in_valid),
        .seed        (first),
        .restart     (last),
        .frame_min   (frame_min),
        .frame_max   (frame_max)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // FILL until the Nth sample is accepted, then one DUMP cycle back to FILL
    always_comb begin
        state_next  = state;
        load_result = 1'b0;
        case (state)
            FILL: begin
                if (last) begin
                    state_next  = DUMP;
                    load_result = 1'b1;
                end
            end
            DUMP: begin
                state_next = FILL;
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // Sample counter and accumulator; the accumulator is re-seeded by the first sample of each frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            acc   <= '0;
        end else if (in_valid) begin
            count <= count + LOG2_DECIM'(1);
            if (last) begin
                acc <= '0;
            end else begin
                acc <= sum;
            end
        end
    end

    // Result registers, valid flag and sticky overrun (set beats clear)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_min   <= '0;
            out_max   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load_result) begin
                out_data  <= avg_full[DATA_W-1:0];
                out_min   <= frame_min;
                out_max   <= frame_max;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end

            if (load_result && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_decimator.sv
// tb/tb_adc_decimator.sv - directed and randomized checks of adc_decimator against a frame-level model
module tb_adc_decimator;

    localparam int LOG2 = 3;
    localparam int N    = 8;
    localparam int DW   = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 clear_overrun = 1'b0;
    logic signed [DW-1:0] out_data;
    logic signed [DW-1:0] out_min;
    logic signed [DW-1:0] out_max;
    logic                 out_valid;
    logic                 overrun;

    int checks = 0;
    int errors = 0;

    int   frame_q[$];
    int   m_data = 0;
    int   m_min = 0;
    int   m_max = 0;
    logic m_valid = 1'b0;
    logic m_ovr = 1'b0;

    adc_decimator #(
        .LOG2_DECIM(LOG2),
        .DATA_W    (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_min      (out_min),
        .out_max      (out_max),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .clear_overrun(clear_overrun)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        assert (act === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s_data", tag), out_data, m_data);
        check($sformatf("%s_min", tag), out_min, m_min);
        check($sformatf("%s_max", tag), out_max, m_max);
        check($sformatf("%s_valid", tag), {31'd0, out_valid}, {31'd0, m_valid});
        check($sformatf("%s_overrun", tag), {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    // Frame-level reference: collect N accepted samples, then publish average/min/max
    task automatic model_update();
        logic complete;
        logic set_ovr;
        logic hs;
        int   s;
        complete = 1'b0;
        set_ovr  = 1'b0;
        hs       = m_valid && out_ready;
        if (in_valid) begin
            frame_q.push_back(int'(in_data));
            if (frame_q.size() == N) begin
                s = 0;
                m_min = frame_q[0];
                m_max = frame_q[0];
                foreach (frame_q[i]) begin
                    s += frame_q[i];
                    if (frame_q[i] < m_min) m_min = frame_q[i];
                    if (frame_q[i] > m_max) m_max = frame_q[i];
                end
                m_data   = floor_div(s);
                set_ovr  = m_valid && !out_ready;
                m_valid  = 1'b1;
                complete = 1'b1;
                frame_q.delete();
            end
        end
        if (!complete && hs) m_valid = 1'b0;
        if (set_ovr) m_ovr = 1'b1;
        else if (clear_overrun) m_ovr = 1'b0;
    endtask

    task automatic step(input logic v, input int d, input logic rdy, input logic clr);
        @(negedge clk);
        in_valid      = v;
        in_data       = DW'(d);
        out_ready     = rdy;
        clear_overrun = clr;
        @(posedge clk);
        model_update();
        #1;
        check_all("step");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        clear_overrun = 1'b0;
        frame_q.delete();
        m_data = 0; m_min = 0; m_max = 0; m_valid = 1'b0; m_ovr = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic v;
        logic r;
        logic c;
        int   d;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset0");
        @(negedge clk);
        reset = 1'b0;

        // Constant frame, result visible the cycle after the 8th sample
        for (int i = 0; i < N; i++) step(1'b1, 1000, 1'b0, 1'b0);
        check("r031_data", out_data, 1000);
        check("r031_min", out_min, 1000);
        check("r031_max", out_max, 1000);
        check("r031_valid", {31'd0, out_valid}, 32'd1);
        step(1'b0, 0, 1'b1, 1'b0);
        check("r031_consumed", {31'd0, out_valid}, 32'd0);

        // Ramp and floor of a negative average
        for (int i = 0; i < N; i++) step(1'b1, i, 1'b0, 1'b0);
        check("r032_ramp_data", out_data, 3);
        check("r032_ramp_min", out_min, 0);
        check("r032_ramp_max", out_max, 7);
        step(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) step(1'b1, (i == N - 1) ? -1 : 0, 1'b0, 1'b0);
        check("r032_floor_data", out_data, -1);
        check("r032_floor_min", out_min, -1);
        step(1'b0, 0, 1'b1, 1'b0);

        // Full-scale extremes
        for (int i = 0; i < N; i++) step(1'b1, -32768, 1'b0, 1'b0);
        check("r033_neg", out_data, -32768);
        step(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) step(1'b1, 32767, 1'b0, 1'b0);
        check("r033_pos", out_data, 32767);
        step(1'b0, 0, 1'b1, 1'b0);

        // Unconsumed result overwritten -> overrun, then cleared
        for (int i = 0; i < N; i++) step(1'b1, i, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) step(1'b1, 50, 1'b0, 1'b0);
        check("r034_ovr", {31'd0, overrun}, 32'd1);
        check("r034_data", out_data, 50);
        step(1'b0, 0, 1'b0, 1'b1);
        check("r034_cleared", {31'd0, overrun}, 32'd0);

        // Completion coinciding with a handshake does not raise overrun
        for (int i = 0; i < N; i++) step(1'b1, 20 + i, (i == N - 1), 1'b0);
        check("r024_ovr", {31'd0, overrun}, 32'd0);
        check("r024_valid", {31'd0, out_valid}, 32'd1);
        check("r024_data", out_data, 23);

        // Overrun set wins over a coincident clear
        for (int i = 0; i < N; i++) step(1'b1, -5, 1'b0, (i == N - 1));
        check("r025_setwins", {31'd0, overrun}, 32'd1);
        step(1'b0, 0, 1'b1, 1'b1);

        // Gapped input with junk on idle cycles
        for (int i = 0; i < N; i++) begin
            step(1'b1, i, 1'b0, 1'b0);
            step(1'b0, 12345 - i * 999, 1'b0, 1'b0);
        end
        check("r035_data", out_data, 3);
        check("r035_max", out_max, 7);
        step(1'b0, 0, 1'b1, 1'b0);

        // Partial frame discarded by reset
        for (int i = 0; i < 5; i++) step(1'b1, -3000, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, 100, 1'b0, 1'b0);
        check("r036_data", out_data, 100);
        check("r036_min", out_min, 100);
        check("r036_max", out_max, 100);
        check("r036_ovr", {31'd0, overrun}, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 5))
                0:       d = -32768;
                1:       d = 32767;
                default: d = int'($signed(16'($urandom)));
            endcase
            step(v, d, r, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
